// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester round-robin arbiter in front of a single shared RAM port.
// Requester 0 is the CPU and requester 1 the loader/DMA. A grant latches the winning
// request into local registers, so the RAM sees a stable request even if the requester
// changes or drops its inputs. A 16-bit wait counter forces completion with ERR_DATA
// when the RAM does not answer within TIMEOUT cycles.
module ram_arbiter #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        ram_valid,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic [3:0]  ram_wstrb,
    input  logic        ram_ready,
    input  logic [31:0] ram_rdata,

    output logic        err,
    output logic        err_src
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    // Last value of the wait counter before the access is forced to complete.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t      state_q;
    state_t      state_d;

    // Requester served by the most recent completion; 1 so requester 0 wins the first tie.
    logic        last_q;

    logic [15:0] wait_q;

    logic [31:0] req_addr_q;
    logic [31:0] req_wdata_q;
    logic [3:0]  req_wstrb_q;

    logic [31:0] held0_q;
    logic [31:0] held1_q;

    logic        err_q;
    logic        err_src_q;

    // Completion decode for the current cycle.
    logic        done;
    logic        timed_out;
    logic [31:0] resp_data;
    logic        grant_now;

    // Next-state logic plus the combinational response path to the requesters.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave
        // one unassigned and infer a latch.
        state_d   = state_q;
        ram_valid = 1'b0;
        done      = 1'b0;
        timed_out = 1'b0;

        case (state_q)
            IDLE: begin
                if (m0_valid && m1_valid) begin
                    // Tie: serve whichever requester did not complete last.
                    state_d = last_q ? GNT0 : GNT1;
                end else if (m0_valid) begin
                    state_d = GNT0;
                end else if (m1_valid) begin
                    state_d = GNT1;
                end
            end

            GNT0, GNT1: begin
                ram_valid = 1'b1;
                if (ram_ready) begin
                    // A RAM answer wins over a timeout landing in the same cycle.
                    done = 1'b1;
                end else if (wait_q == WAIT_LAST) begin
                    done      = 1'b1;
                    timed_out = 1'b1;
                end
                if (done) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        m0_ready  = done && (state_q == GNT0);
        m1_ready  = done && (state_q == GNT1);
        resp_data = timed_out ? ERR_DATA : ram_rdata;

        // Reset is synchronous, so the state register may still hold a grant during the
        // reset cycle; the request and strobes are suppressed so the access is abandoned.
        if (reset) begin
            ram_valid = 1'b0;
            m0_ready  = 1'b0;
            m1_ready  = 1'b0;
        end

        m0_rdata  = m0_ready ? resp_data : held0_q;
        m1_rdata  = m1_ready ? resp_data : held1_q;
        grant_now = (state_q == IDLE) && (state_d != IDLE);
    end

    // State register and round-robin last-grant tracking.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            if (done) begin
                last_q <= (state_q == GNT1);
            end
        end
    end

    // Wait counter: cleared on grant, advanced each granted cycle without an answer.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_q <= 16'd0;
        end else if (grant_now) begin
            wait_q <= 16'd0;
        end else if (ram_valid && !done) begin
            wait_q <= wait_q + 16'd1;
        end
    end

    // Request registers: capture the winner's request on the grant edge only.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_addr_q  <= 32'd0;
            req_wdata_q <= 32'd0;
            req_wstrb_q <= 4'd0;
        end else if (grant_now) begin
            if (state_d == GNT0) begin
                req_addr_q  <= m0_addr;
                req_wdata_q <= m0_wdata;
                req_wstrb_q <= m0_wstrb;
            end else begin
                req_addr_q  <= m1_addr;
                req_wdata_q <= m1_wdata;
                req_wstrb_q <= m1_wstrb;
            end
        end
    end

    // Held read data: each requester keeps the last value delivered to it.
    always_ff @(posedge clk) begin
        if (reset) begin
            held0_q <= 32'd0;
            held1_q <= 32'd0;
        end else begin
            if (m0_ready) begin
                held0_q <= resp_data;
            end
            if (m1_ready) begin
                held1_q <= resp_data;
            end
        end
    end

    // Sticky timeout flag and the requester that timed out most recently.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q     <= 1'b0;
            err_src_q <= 1'b0;
        end else if (timed_out) begin
            err_q     <= 1'b1;
            err_src_q <= (state_q == GNT1);
        end
    end

    assign ram_addr  = req_addr_q;
    assign ram_wdata = req_wdata_q;
    assign ram_wstrb = req_wstrb_q;
    assign err       = err_q;
    assign err_src   = err_src_q;

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles to wait for ram_ready before forcing completion (legal 1..65535).
REQ-002 Parameter ERR_DATA, default 32'hDEADBEEF: read data returned on a timed-out access.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 m0_valid, m0_addr[31:0], m0_wdata[31:0], m0_wstrb[3:0]  input  requester 0 (CPU) request; m0_wstrb==0 means read.
REQ-006 m0_ready  output  1  requester 0 completion strobe; m0_rdata[31:0] output read data.
REQ-007 m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata: the same set for requester 1 (loader/DMA), identical widths.
REQ-008 ram_valid  output  1; ram_addr[31:0], ram_wdata[31:0], ram_wstrb[3:0]  outputs  shared RAM request.
REQ-009 ram_ready  input  1; ram_rdata[31:0]  input  RAM completion and read data; valid in the ram_ready cycle.
REQ-010 err  output  1  sticky timeout flag; err_src  output  1  requester that timed out last.

Function
REQ-011 The FSM SHALL have states IDLE, GNT0 and GNT1.
REQ-012 In IDLE with exactly one mX_valid high, the FSM SHALL enter GNTX on the next edge.
REQ-013 In IDLE with both valid, the FSM SHALL grant the requester not served last (round-robin via a last-grant register; reset value 1, so m0 wins the first tie).
REQ-014 On the IDLE->GNTX edge, the block SHALL latch the requester's addr/wdata/wstrb into request registers.
REQ-015 ram_addr/ram_wdata/ram_wstrb SHALL be driven only from the request registers.
REQ-016 ram_valid SHALL be 1 exactly while in GNT0/GNT1.
REQ-017 In GNTX with ram_ready=1, mX_ready SHALL be 1 in that same cycle and mX_rdata SHALL equal ram_rdata combinationally.
REQ-018 In that cycle the FSM SHALL return to IDLE and set last-grant to X.
REQ-019 Minimum latency from mX_valid rising in IDLE to mX_ready: 2 cycles when the RAM answers in its first ready cycle.
REQ-020 The non-granted requester's ready SHALL be 0.
REQ-021 Outside the completion cycle, mX_rdata SHALL hold its last delivered value (registered copy, reset 0).
REQ-022 A requester dropping valid while granted SHALL NOT abort the access: ram_valid stays high until ram_ready or timeout, and the response strobe is still issued.
REQ-023 A 16-bit wait counter SHALL clear on grant and increment each GNTX cycle without ram_ready.
REQ-024 When the counter equals TIMEOUT-1 with ram_ready low, the block SHALL assert mX_ready with mX_rdata=ERR_DATA, set err=1 and err_src=X, and return to IDLE.
REQ-025 If ram_ready and the timeout coincide, the ram_ready completion SHALL win and err SHALL be unchanged.
REQ-026 IDLE SHALL always spend one cycle, so back-to-back grants are at least 1 idle cycle apart; a completing requester still valid competes under round-robin.
REQ-027 err SHALL clear only on reset.

Reset
REQ-028 With reset=1 at an edge: FSM to IDLE, counter 0, request registers 0, last-grant 1, err 0, err_src 0, held rdata 0.
REQ-029 During reset: ram_valid, m0_ready and m1_ready SHALL be 0.
REQ-030 Reset asserted mid-grant SHALL abandon the access with no ready strobe issued.
REQ-031 All outputs SHALL be defined in the first cycle after reset deasserts.

Verification
REQ-032 m0 read at 0x10, RAM ready 1 cycle after ram_valid with rdata 0x12345678 -> m0_ready 1 cycle, m0_rdata=0x12345678, ram_wstrb=0.
REQ-033 m0 and m1 valid together, continuously, for 4 accesses -> grant order 0,1,0,1; never both ready in one cycle.
REQ-034 m1 write 0xA5A5A5A5, wstrb 4'b0011, addr 0x40, m1 inputs changed after grant -> RAM sees the latched original values.
REQ-035 TIMEOUT=8, ram_ready never asserted -> m0_ready 8 cycles after grant, rdata=0xDEADBEEF, err=1, err_src=0; next access completes normally with err still 1.
REQ-036 ram_ready on the same cycle as timeout -> normal data delivered, err stays 0.
REQ-037 Reset pulsed during GNT1 -> no m1_ready, ram_valid 0 the next cycle, state IDLE, last-grant 1.
